// File: rtl/led_pattern_ticker_pkg.sv
// Shared definitions for the LED pattern ticker: channel modes, walk direction
// and a helper that sizes counters from their range.
package led_pattern_ticker_pkg;

    typedef enum logic [1:0] {
        MODE_BIN   = 2'b00,
        MODE_GRAY  = 2'b01,
        MODE_WALK  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // A counter spanning 0..range-1 never collapses below one bit.
    function automatic int cntWidth(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_ticker_channel.sv
// One pattern channel: holds its registered mode, binary step counter, walk
// direction and the registered output pattern.
module led_pattern_ticker_channel
    import led_pattern_ticker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_clear,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_pattern
);

    mode_e            r_mode;
    dir_e             r_dir;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_pattern;

    mode_e            w_newMode;
    logic             w_modeChange;
    logic [WIDTH-1:0] w_bInc;
    logic [WIDTH-1:0] w_advPattern;
    dir_e             w_advDir;

    function automatic logic [WIDTH-1:0] initPattern(input mode_e m);
        return (m == MODE_WALK) ? WIDTH'(1) : '0;
    endfunction

    assign w_newMode    = mode_e'(i_mode);
    assign w_modeChange = (w_newMode != r_mode);
    assign w_bInc       = r_b + WIDTH'(1);

    // Walk flips direction on reaching an end, so an end position lasts only one tick.
    always_comb begin
        w_advPattern = r_pattern;
        w_advDir     = r_dir;
        case (r_mode)
            MODE_BIN:   w_advPattern = w_bInc;
            MODE_GRAY:  w_advPattern = w_bInc ^ (w_bInc >> 1);
            MODE_WALK: begin
                if (r_dir == DIR_LEFT) begin
                    if (r_pattern[WIDTH-1]) begin
                        w_advPattern = r_pattern >> 1;
                        w_advDir     = DIR_RIGHT;
                    end else begin
                        w_advPattern = r_pattern << 1;
                    end
                end else begin
                    if (r_pattern[0]) begin
                        w_advPattern = r_pattern << 1;
                        w_advDir     = DIR_LEFT;
                    end else begin
                        w_advPattern = r_pattern >> 1;
                    end
                end
            end
            MODE_BLINK: w_advPattern = ~r_pattern;
        endcase
    end

    // Re-init (mode change, then clear) takes precedence over a coinciding advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_BIN;
            r_dir     <= DIR_LEFT;
            r_b       <= '0;
            r_pattern <= '0;
        end else if (w_modeChange) begin
            r_mode    <= w_newMode;
            r_dir     <= DIR_LEFT;
            r_b       <= '0;
            r_pattern <= initPattern(w_newMode);
        end else if (i_clear) begin
            r_dir     <= DIR_LEFT;
            r_b       <= '0;
            r_pattern <= initPattern(r_mode);
        end else if (i_adv) begin
            r_dir     <= w_advDir;
            r_b       <= w_bInc;
            r_pattern <= w_advPattern;
        end
    end

    assign o_pattern = r_pattern;

endmodule

// File: rtl/led_pattern_ticker.sv
// Heartbeat/status generator: a free-running prescaler produces an exact-period
// tick shared by all pattern channels, plus an independent clock-enable divider.
module led_pattern_ticker
    import led_pattern_ticker_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int CE_DIV     = 2,
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [CHANNELS-1:0]       clear_i,
    input  logic [2*CHANNELS-1:0]     mode_i,
    output logic                      ce_o,
    output logic                      tick_o,
    output logic [WIDTH*CHANNELS-1:0] pattern_o
);

    localparam int TICK_CYCLES = CLOCK_FREQ / TICK_HZ;
    localparam int TICK_W      = cntWidth(TICK_CYCLES);
    localparam int CE_W        = cntWidth(CE_DIV);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_DIV - 1);

    logic [TICK_W-1:0]   r_tickCnt;
    logic                r_tick;
    logic [CE_W-1:0]     r_ceCnt;
    logic                r_ce;
    logic [CHANNELS-1:0] w_adv;

    // The tick is registered from the terminal count, so it lands one cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tickCnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= (r_tickCnt == TICK_LAST);
            r_tickCnt <= (r_tickCnt == TICK_LAST) ? '0 : r_tickCnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ceCnt <= '0;
            r_ce    <= 1'b0;
        end else begin
            r_ce    <= (r_ceCnt == CE_LAST);
            r_ceCnt <= (r_ceCnt == CE_LAST) ? '0 : r_ceCnt + CE_W'(1);
        end
    end

    assign w_adv  = {CHANNELS{r_tick}} & en_i;
    assign tick_o = r_tick;
    assign ce_o   = r_ce;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        led_pattern_ticker_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_adv    (w_adv[c]),
            .i_clear  (clear_i[c]),
            .i_mode   (mode_i[2*c +: 2]),
            .o_pattern(pattern_o[WIDTH*c +: WIDTH])
        );
    end

endmodule

// File: tb/tb_led_pattern_ticker.sv
// Scoreboard bench: stimulus updates a step-count model and queues the expected
// patterns for each tick; a monitor pops them whenever the DUT ticks.
module tb_led_pattern_ticker;

    localparam int CF          = 100;
    localparam int TH          = 10;
    localparam int TICKS       = CF / TH;
    localparam int CE          = 2;
    localparam int CH          = 2;
    localparam int W           = 8;
    localparam int WALK_PERIOD = 2 * (W - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [CH-1:0]     en = '0;
    logic [CH-1:0]     clr = '0;
    logic [2*CH-1:0]   mode = '0;
    logic              ceO;
    logic              tickO;
    logic [W*CH-1:0]   patternO;

    int                assertCount = 0;
    int                failCount = 0;
    int                k = 0;
    logic [W*CH-1:0]   expQ[$];
    int                mMode[CH];
    int                mStep[CH];

    led_pattern_ticker #(
        .CLOCK_FREQ(CF),
        .TICK_HZ   (TH),
        .CE_DIV    (CE),
        .CHANNELS  (CH),
        .WIDTH     (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .clear_i  (clr),
        .mode_i   (mode),
        .ce_o     (ceO),
        .tick_o   (tickO),
        .pattern_o(patternO)
    );

    always #5 clk = ~clk;

    // Pattern after a given number of advances since the last re-init.
    function automatic logic [W-1:0] modelPattern(input int md, input int step);
        int s;
        int p;
        s = step % (1 << W);
        p = step % WALK_PERIOD;
        case (md)
            0:       return W'(s);
            1:       return W'(s ^ (s >> 1));
            2:       return (p <= W - 1) ? W'(1 << p) : W'(1 << (WALK_PERIOD - p));
            default: return (step % 2 == 1) ? '1 : '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, k);
        end
    endtask

    function automatic bit isTickCycle();
        return (k > 0) && (k % TICKS == 0);
    endfunction

    // Apply the current inputs for one clock, updating the model and queueing on ticks.
    task automatic applyStimulus();
        bit              tickNow;
        int              md;
        logic [W*CH-1:0] exp;
        tickNow = isTickCycle();
        for (int c = 0; c < CH; c++) begin
            md = int'(mode[2*c +: 2]);
            if (md != mMode[c]) begin
                mMode[c] = md;
                mStep[c] = 0;
            end else if (clr[c]) begin
                mStep[c] = 0;
            end else if (tickNow && en[c]) begin
                mStep[c]++;
            end
        end
        if (tickNow) begin
            exp = '0;
            for (int c = 0; c < CH; c++)
                exp[W*c +: W] = modelPattern(mMode[c], mStep[c]);
            expQ.push_back(exp);
        end
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic runTicks(input int n);
        repeat (n) begin
            while (!isTickCycle()) applyStimulus();
            applyStimulus();
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("reset pattern_o", 32'(patternO), 32'h0);
        checkOutput("reset tick_o", 32'(tickO), 32'h0);
        checkOutput("reset ce_o", 32'(ceO), 32'h0);
        expQ.delete();
        for (int c = 0; c < CH; c++) begin
            mMode[c] = 0;
            mStep[c] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    initial begin : monitor
        int              cyc;
        bit              prevTick;
        logic [W*CH-1:0] exp;
        cyc = 0;
        prevTick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                cyc = 0;
                prevTick = 1'b0;
            end else begin
                cyc++;
                checkOutput("tick_o timing", 32'(tickO), 32'(cyc % TICKS == 0));
                checkOutput("ce_o timing", 32'(ceO), 32'(cyc % CE == 0));
                if (prevTick) begin
                    if (expQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL scoreboard underflow: DUT ticked with no expected entry (cycle %0d)", cyc);
                    end else begin
                        exp = expQ.pop_front();
                        for (int c = 0; c < CH; c++)
                            checkOutput($sformatf("ch%0d pattern", c),
                                        32'(patternO[W*c +: W]), 32'(exp[W*c +: W]));
                    end
                end
                prevTick = tickO;
            end
        end
    end

    initial begin : stimulus
        #2;
        doReset();

        // Channel 0 counts in binary through a full wrap; channel 1 stays idle.
        en = 2'b01;
        runTicks(300);

        mode[3:2] = 2'b01;
        en = 2'b10;
        runTicks(4);

        mode[1:0] = 2'b10;
        en = 2'b11;
        runTicks(16);

        // Clear on channel 0 and a mode change on channel 1 land in the tick cycle.
        mode[1:0] = 2'b00;
        runTicks(3);
        while (!isTickCycle()) applyStimulus();
        clr = 2'b01;
        mode[3:2] = 2'b10;
        applyStimulus();
        clr = '0;
        runTicks(2);

        // Randomised enables, clears and mode changes, on and off the tick.
        repeat (150) begin
            while (!isTickCycle()) begin
                for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) mode[2*$urandom_range(0, CH-1) +: 2] = 2'($urandom_range(0, 3));
                applyStimulus();
                clr = '0;
            end
            en = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                clr[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 7) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            applyStimulus();
            clr = '0;
        end

        // Bring channel 0 to 0x37 then reset mid-pattern while ce_o is high.
        mode = '0;
        en = 2'b01;
        clr = 2'b01;
        applyStimulus();
        clr = '0;
        runTicks(8'h37);
        while (k % TICKS != 6) applyStimulus();
        doReset();

        en = 2'b11;
        mode = 4'b0110;
        runTicks(5);
        repeat (3) applyStimulus();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
